clause_output_sched: RTL and testbench

//  Run controller between the clause comparator stream and the clause-output word buffer.

---
 rtl/clause_output_sched_pkg.sv | 39 +++
 rtl/clause_output_sched_if.sv | 13 +
 rtl/clause_output_sched_fire_decode.sv | 20 ++
 rtl/clause_output_sched.sv | 234 +++++++++++++++++++++++
 tb/tb_clause_output_sched.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clause_output_sched_pkg.sv
// Shared constants, comparator payload layout and run states for the clause-output scheduler.
// The comparator word packs {idx, fire, polarity}; chunk/pos split the clause index per buffer word.
package clause_sched_pkg;

  localparam int unsigned INT_SIZE      = 32;
  localparam int unsigned CLAUSE_CHUNKS = 63;
  localparam int unsigned ADDR_W        = 6;

  localparam int unsigned CMP_POL_BIT  = 0;
  localparam int unsigned CMP_FIRE_BIT = 1;
  localparam int unsigned CMP_IDX_LSB  = 2;
  localparam int unsigned CMP_IDX_MSB  = 18;
  localparam int unsigned CMP_W        = CMP_IDX_MSB + 1;

  localparam int unsigned IDX_W   = CMP_IDX_MSB - CMP_IDX_LSB + 1;
  localparam int unsigned POS_W   = $clog2(INT_SIZE);
  localparam int unsigned CHUNK_W = IDX_W - POS_W;
  localparam int unsigned CNT_W   = $clog2(CLAUSE_CHUNKS * INT_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    FILL    = 3'd2,
    TAIL    = 3'd3,
    DONE    = 3'd4
  } sched_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             fire;
    logic             pol;
  } cmp_word_t;

  // One-hot bit for a clause position inside its output word.
  function automatic logic [INT_SIZE-1:0] pos_mask(input logic [POS_W-1:0] pos);
    pos_mask = INT_SIZE'(1) << pos;
  endfunction

endpackage

// File: rtl/clause_output_sched_if.sv
// Comparator-word stream between the clause comparator and the output scheduler.
interface clause_output_sched_if;
  import clause_sched_pkg::*;

  logic      cmp_valid;
  logic      cmp_ready;
  cmp_word_t cmp_word;
  logic      cmp_last;

  modport master (output cmp_valid, output cmp_word, output cmp_last, input cmp_ready);
  modport slave  (input cmp_valid, input cmp_word, input cmp_last, output cmp_ready);

endinterface

// File: rtl/clause_output_sched_fire_decode.sv
// Combinational decode of a comparator word into fire qualifier, buffer chunk and bit position.
module clause_fire_decode
  import clause_sched_pkg::*;
(
  input  logic [CMP_W-1:0]   i_cmp_word,
  input  logic               i_predict,
  output logic               o_fire_c,
  output logic [CHUNK_W-1:0] o_chunk_c,
  output logic [POS_W-1:0]   o_pos_c
);

  logic [IDX_W-1:0] w_idx;

  assign w_idx     = i_cmp_word[CMP_IDX_MSB:CMP_IDX_LSB];
  // Prediction mode masks negative-polarity clauses.
  assign o_fire_c  = i_cmp_word[CMP_FIRE_BIT] && !(i_predict && i_cmp_word[CMP_POL_BIT]);
  assign o_chunk_c = w_idx[IDX_W-1:POS_W];
  assign o_pos_c   = w_idx[POS_W-1:0];

endmodule

// File: rtl/clause_output_sched.sv
// Run controller: folds fired clauses into per-chunk words and writes every buffer word once, in order.
// Optional build macro CLAUSE_SCHED_COUNT_EN adds o_fire_count (accepted in-range, in-order fired bits).
module clause_output_sched
  import clause_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_flag_n,
  input  logic                    i_start,
  input  logic                    i_stop_flag,
  input  logic                    i_predict,
  clause_output_sched_if.slave    cmp_if,
  output logic                    o_wr_en,
  output logic [ADDR_W-1:0]       o_wr_addr,
  output logic [INT_SIZE-1:0]     o_wr_data,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_order_err,
  output logic                    o_range_err
`ifdef CLAUSE_SCHED_COUNT_EN
  ,
  output logic [CNT_W-1:0]        o_fire_count
`endif
);

  localparam logic [2:0] ST_IDLE    = IDLE;
  localparam logic [2:0] ST_COLLECT = COLLECT;
  localparam logic [2:0] ST_FILL    = FILL;
  localparam logic [2:0] ST_TAIL    = TAIL;
  localparam logic [2:0] ST_DONE    = DONE;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CLAUSE_CHUNKS - 1);

  logic [2:0]          r_state,     w_state_nxt;
  logic [ADDR_W-1:0]   r_cur,       w_cur_nxt;
  logic [INT_SIZE-1:0] r_acc,       w_acc_nxt;
  logic [ADDR_W-1:0]   r_tgt,       w_tgt_nxt;
  logic [INT_SIZE-1:0] r_pend,      w_pend_nxt;
  logic                r_last,      w_last_nxt;
  logic                r_wr_en,     w_wr_en_nxt;
  logic [ADDR_W-1:0]   r_wr_addr,   w_wr_addr_nxt;
  logic [INT_SIZE-1:0] r_wr_data,   w_wr_data_nxt;
  logic                r_busy,      w_busy_nxt;
  logic                r_done,      w_done_nxt;
  logic                r_order_err, w_oerr_nxt;
  logic                r_range_err, w_rerr_nxt;
`ifdef CLAUSE_SCHED_COUNT_EN
  logic [CNT_W-1:0]    r_fire_count, w_cnt_nxt;
`endif

  logic                w_fire;
  logic [CHUNK_W-1:0]  w_chunk;
  logic [POS_W-1:0]    w_pos;
  logic [CHUNK_W-1:0]  w_cur_ext;
  logic [INT_SIZE-1:0] w_mask;
  logic [ADDR_W-1:0]   w_cur_inc;
  logic                w_ready_c;

  clause_fire_decode u_decode (
    .i_cmp_word (cmp_if.cmp_word),
    .i_predict  (i_predict),
    .o_fire_c   (w_fire),
    .o_chunk_c  (w_chunk),
    .o_pos_c    (w_pos)
  );

  assign w_cur_ext = CHUNK_W'(r_cur);
  assign w_cur_inc = r_cur + ADDR_W'(1);
  assign w_mask    = pos_mask(w_pos);

  // Ready only while collecting; a freeze withdraws it in the same cycle.
  assign w_ready_c        = (r_state == ST_COLLECT) && !i_stop_flag;
  assign cmp_if.cmp_ready = w_ready_c;

  // Next-state and next-output decision.
  always_comb begin
    w_state_nxt   = r_state;
    w_cur_nxt     = r_cur;
    w_acc_nxt     = r_acc;
    w_tgt_nxt     = r_tgt;
    w_pend_nxt    = r_pend;
    w_last_nxt    = r_last;
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_oerr_nxt    = r_order_err;
    w_rerr_nxt    = r_range_err;
`ifdef CLAUSE_SCHED_COUNT_EN
    w_cnt_nxt     = r_fire_count;
`endif

    if (!i_stop_flag) begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = ST_COLLECT;
            w_busy_nxt  = 1'b1;
            w_cur_nxt   = '0;
            w_acc_nxt   = '0;
            w_oerr_nxt  = 1'b0;
            w_rerr_nxt  = 1'b0;
`ifdef CLAUSE_SCHED_COUNT_EN
            w_cnt_nxt   = '0;
`endif
          end
        end

        ST_COLLECT: begin
          if (cmp_if.cmp_valid) begin
            if (w_fire) begin
              if (w_chunk >= CHUNK_W'(CLAUSE_CHUNKS)) begin
                w_rerr_nxt = 1'b1;
              end else if (w_chunk < w_cur_ext) begin
                w_oerr_nxt = 1'b1;
              end else if (w_chunk == w_cur_ext) begin
                w_acc_nxt = r_acc | w_mask;
`ifdef CLAUSE_SCHED_COUNT_EN
                w_cnt_nxt = r_fire_count + CNT_W'(1);
`endif
              end else begin
                // Moving forward: flush the current word first.
                w_wr_en_nxt   = 1'b1;
                w_wr_addr_nxt = r_cur;
                w_wr_data_nxt = r_acc;
`ifdef CLAUSE_SCHED_COUNT_EN
                w_cnt_nxt     = r_fire_count + CNT_W'(1);
`endif
                if (w_chunk == w_cur_ext + CHUNK_W'(1)) begin
                  w_cur_nxt = ADDR_W'(w_chunk);
                  w_acc_nxt = w_mask;
                end else begin
                  w_state_nxt = ST_FILL;
                  w_tgt_nxt   = ADDR_W'(w_chunk);
                  w_pend_nxt  = w_mask;
                  w_last_nxt  = cmp_if.cmp_last;
                end
              end
            end
            if (cmp_if.cmp_last && (w_state_nxt == ST_COLLECT)) begin
              w_state_nxt = ST_TAIL;
            end
          end
        end

        ST_FILL: begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_cur_inc;
          w_wr_data_nxt = '0;
          if (w_cur_inc == (r_tgt - ADDR_W'(1))) begin
            w_cur_nxt   = r_tgt;
            w_acc_nxt   = r_pend;
            w_state_nxt = r_last ? ST_TAIL : ST_COLLECT;
          end else begin
            w_cur_nxt = w_cur_inc;
          end
        end

        ST_TAIL: begin
          // First beat flushes the accumulator, the rest pad with zero words.
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = r_cur;
          w_wr_data_nxt = r_acc;
          w_acc_nxt     = '0;
          if (r_cur == LAST_ADDR) begin
            w_state_nxt = ST_DONE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_cur_nxt = w_cur_inc;
          end
        end

        ST_DONE: begin
          w_state_nxt = ST_IDLE;
        end

        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_flag_n) begin
    if (!rst_flag_n) begin
      r_state     <= ST_IDLE;
      r_cur       <= '0;
      r_acc       <= '0;
      r_tgt       <= '0;
      r_pend      <= '0;
      r_last      <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_order_err <= 1'b0;
      r_range_err <= 1'b0;
`ifdef CLAUSE_SCHED_COUNT_EN
      r_fire_count <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cur       <= w_cur_nxt;
      r_acc       <= w_acc_nxt;
      r_tgt       <= w_tgt_nxt;
      r_pend      <= w_pend_nxt;
      r_last      <= w_last_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_order_err <= w_oerr_nxt;
      r_range_err <= w_rerr_nxt;
`ifdef CLAUSE_SCHED_COUNT_EN
      r_fire_count <= w_cnt_nxt;
`endif
    end
  end

  assign o_wr_en     = r_wr_en;
  assign o_wr_addr   = r_wr_addr;
  assign o_wr_data   = r_wr_data;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_order_err = r_order_err;
  assign o_range_err = r_range_err;
`ifdef CLAUSE_SCHED_COUNT_EN
  assign o_fire_count = r_fire_count;
`endif

endmodule

// File: tb/tb_clause_output_sched.sv
// Bench for clause_output_sched: directed and random runs scored against a buffer-image reference model.
module tb_clause_output_sched;
  import clause_sched_pkg::*;

  logic                clk = 1'b0;
  logic                rst_flag_n = 1'b0;
  logic                start = 1'b0;
  logic                stop_flag = 1'b0;
  logic                predict = 1'b0;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [INT_SIZE-1:0] wr_data;
  logic                busy, done, order_err, range_err;
`ifdef CLAUSE_SCHED_COUNT_EN
  logic [CNT_W-1:0]    fire_count;
`endif

  clause_output_sched_if cmp_if ();

  always #5 clk = ~clk;

  clause_output_sched dut (
    .clk         (clk),
    .rst_flag_n  (rst_flag_n),
    .i_start     (start),
    .i_stop_flag (stop_flag),
    .i_predict   (predict),
    .cmp_if      (cmp_if),
    .o_wr_en     (wr_en),
    .o_wr_addr   (wr_addr),
    .o_wr_data   (wr_data),
    .o_busy      (busy),
    .o_done      (done),
    .o_order_err (order_err),
    .o_range_err (range_err)
`ifdef CLAUSE_SCHED_COUNT_EN
    ,
    .o_fire_count(fire_count)
`endif
  );

  typedef struct { int unsigned idx; bit fire; bit pol; } beat_t;
  typedef struct { int unsigned addr; logic [INT_SIZE-1:0] data; } wr_t;

  int n_checks = 0;
  int n_fail   = 0;

  beat_t               beats[$];
  int                  stop_at = -1;
  logic [INT_SIZE-1:0] exp_mem [CLAUSE_CHUNKS];
  bit                  exp_oerr, exp_rerr;
  wr_t                 wr_log[$];
  int                  done_cnt = 0;
  int                  done_wr_n = 0;
  bit                  stop_q = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Write/done capture plus freeze checks, sampled mid-cycle.
  always @(posedge clk) stop_q <= stop_flag;
  always @(negedge clk) begin
    if (wr_en) wr_log.push_back('{addr: 32'(wr_addr), data: wr_data});
    if (done) begin
      done_cnt++;
      done_wr_n = wr_log.size();
    end
    if (stop_q) chk("stop_no_write", 64'(wr_en), 64'd0);
    if (stop_flag) chk("stop_no_ready", 64'(cmp_if.cmp_ready), 64'd0);
  end

  // Reference: final buffer image from the run's beats, ignoring all timing.
  function automatic void build_model();
    int unsigned cur;
    cur = 0;
    exp_oerr = 1'b0;
    exp_rerr = 1'b0;
    for (int i = 0; i < int'(CLAUSE_CHUNKS); i++) exp_mem[i] = '0;
    foreach (beats[i]) begin
      int unsigned c;
      c = beats[i].idx / 32;
      if (beats[i].fire && !(predict && beats[i].pol)) begin
        if (c >= CLAUSE_CHUNKS) exp_rerr = 1'b1;
        else if (c < cur) exp_oerr = 1'b1;
        else begin
          exp_mem[c][beats[i].idx % 32] = 1'b1;
          cur = c;
        end
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_beat(input int unsigned idx, input bit fire, input bit pol);
    beats.push_back('{idx: idx, fire: fire, pol: pol});
  endtask

  task automatic start_run(input string tag);
    wr_log.delete();
    done_cnt = 0;
    done_wr_n = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_on_start"}, 64'(busy), 64'd1);
    chk({tag, "_errs_cleared"}, 64'({order_err, range_err}), 64'd0);
  endtask

  task automatic send_beats(input string tag);
    int unsigned cur;
    cur = 0;
    foreach (beats[i]) begin
      bit          rdy;
      bit          f;
      int          guard;
      int unsigned c;
      c = beats[i].idx / 32;
      f = beats[i].fire && !(predict && beats[i].pol);
      cmp_if.cmp_valid = 1'b1;
      cmp_if.cmp_word  = '{idx: 17'(beats[i].idx), fire: beats[i].fire, pol: beats[i].pol};
      cmp_if.cmp_last  = (i == beats.size() - 1);
      rdy = 1'b0;
      guard = 0;
      while (!rdy && guard < 300) begin
        @(negedge clk);
        rdy = cmp_if.cmp_ready;
        tick();
        guard++;
      end
      cmp_if.cmp_valid = 1'b0;
      cmp_if.cmp_last  = 1'b0;
      if (!rdy) begin
        chk({tag, "_accept_timeout"}, 64'(rdy), 64'd1);
        return;
      end
      if (f && c < CLAUSE_CHUNKS && c >= cur) begin
        if (c > cur + 1) begin
          @(negedge clk);
          chk({tag, "_fill_ready_low"}, 64'(cmp_if.cmp_ready), 64'd0);
          tick();
        end
        cur = c;
      end
      if (i == stop_at) begin
        tick();
        stop_flag = 1'b1;
        repeat (3) tick();
        stop_flag = 1'b0;
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic finish_run(input string tag);
    int guard;
    int n;
    guard = 0;
    while (done_cnt == 0 && guard < 400) begin
      tick();
      guard++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_after_last_write"}, 64'(done_wr_n), 64'(CLAUSE_CHUNKS));
    repeat (3) tick();
    chk({tag, "_single_done"}, 64'(done_cnt), 64'd1);
    chk({tag, "_write_count"}, 64'(wr_log.size()), 64'(CLAUSE_CHUNKS));
    n = (wr_log.size() < int'(CLAUSE_CHUNKS)) ? wr_log.size() : int'(CLAUSE_CHUNKS);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_log[i].addr), 64'(i));
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_log[i].data), 64'(exp_mem[i]));
    end
    chk({tag, "_order_err"}, 64'(order_err), 64'(exp_oerr));
    chk({tag, "_range_err"}, 64'(range_err), 64'(exp_rerr));
    chk({tag, "_busy_off"}, 64'(busy), 64'd0);
  endtask

  task automatic run_case(input string tag, input bit pred, input int st);
    predict = pred;
    stop_at = st;
    build_model();
    start_run(tag);
    send_beats(tag);
    finish_run(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    cmp_if.cmp_valid = 1'b0;
    cmp_if.cmp_word  = '0;
    cmp_if.cmp_last  = 1'b0;
    repeat (3) tick();
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_data", 64'(wr_data), 64'd0);
    chk("rst_busy_done", 64'({busy, done}), 64'd0);
    chk("rst_errs", 64'({order_err, range_err}), 64'd0);
    chk("rst_ready", 64'(cmp_if.cmp_ready), 64'd0);
    rst_flag_n = 1'b1;
    repeat (2) tick();

    beats.delete(); add_beat(3, 1, 0); add_beat(40, 1, 1); add_beat(2015, 1, 0);
    run_case("t1", 1'b0, -1);
    chk("t1_addr62_bit31", 64'(exp_mem[62]), 64'h8000_0000);

    beats.delete(); add_beat(7, 1, 1);
    run_case("t2_predict", 1'b1, -1);
    run_case("t2_nopredict", 1'b0, -1);

    beats.delete(); add_beat(5, 1, 0); add_beat(200, 1, 0);
    run_case("t3_fill_stop", 1'b0, 1);

    beats.delete(); add_beat(100, 1, 0); add_beat(10, 1, 0);
    run_case("t4_order", 1'b0, -1);
    beats.delete(); add_beat(0, 1, 0);
    run_case("t4_clear", 1'b0, -1);

    beats.delete(); add_beat(2016, 1, 0);
    run_case("t5_range", 1'b0, -1);

    for (int r = 0; r < 20; r++) begin
      int unsigned cur;
      int          n;
      int          st;
      cur = 0;
      beats.delete();
      n = int'($urandom_range(1, 12));
      for (int k = 0; k < n; k++) begin
        int unsigned c;
        int unsigned sel;
        sel = $urandom_range(0, 99);
        if (sel < 8) c = $urandom_range(63, 4095);
        else if (sel < 16 && cur > 0) c = $urandom_range(0, cur - 1);
        else begin
          c = cur + $urandom_range(0, 4);
          if (c > 62) c = 62;
          cur = c;
        end
        add_beat(c * 32 + $urandom_range(0, 31), $urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)));
      end
      st = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      run_case($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), st);
    end

    // Reset while the tail padding is being written.
    beats.delete(); add_beat(0, 1, 0);
    predict = 1'b0;
    stop_at = -1;
    start_run("t6_rst");
    send_beats("t6_rst");
    repeat (5) tick();
    rst_flag_n = 1'b0;
    #1;
    chk("t6_rst_wr_en", 64'(wr_en), 64'd0);
    chk("t6_rst_wr_data", 64'(wr_data), 64'd0);
    chk("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("t6_rst_busy_done", 64'({busy, done}), 64'd0);
    chk("t6_rst_ready", 64'(cmp_if.cmp_ready), 64'd0);
    begin
      int n_before;
      n_before = wr_log.size();
      repeat (3) tick();
      chk("t6_no_writes_in_reset", 64'(wr_log.size()), 64'(n_before));
      rst_flag_n = 1'b1;
      repeat (5) tick();
      chk("t6_no_writes_after_reset", 64'(wr_log.size()), 64'(n_before));
    end
    chk("t6_no_done", 64'(done_cnt), 64'd0);
    chk("t6_idle_busy", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
